de1_soc_key_ctrl: RTL and testbench

DE1_SOC_KEY_CTRL -- requirements
Module: de1_soc_key_ctrl

---
 rtl/de1_soc_key_ctrl.sv | 124 ++++++++++++
 tb/tb_de1_soc_key_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/de1_soc_key_ctrl.sv
// Four-key pushbutton controller for the DE1-SoC: synchronizes and debounces the KEY inputs,
// latches press events, and exposes them through an Avalon-MM slave with a masked level interrupt.
module de1_soc_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [3:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] LP_ADDR_LVL  = 2'd0;
    localparam logic [1:0] LP_ADDR_MASK = 2'd1;
    localparam logic [1:0] LP_ADDR_SYNC = 2'd2;
    localparam logic [1:0] LP_ADDR_EDGE = 2'd3;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_lvl;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_edgecap;
    logic [3:0]       r_mask;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [3:0]       w_accept;
    logic [3:0]       w_press;
    logic [3:0]       w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_wr     = chipselect && !write_n;
    assign w_unused = ^writedata[31:4];

    // Two-flop synchronizer; resets to the released (high) level so no false press follows reset.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // A key is accepted once its synchronized level has disagreed with lvl for DEBOUNCE_CYCLES edges.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < 4; i++) begin
            w_accept[i] = (r_sync2[i] != r_lvl[i]) && (r_cnt[i] == LP_CNT_MAX);
        end
    end

    assign w_press = w_accept & r_lvl;

    // NOTE: the counters are a handful of flops, not a RAM, so they take the async reset like the rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lvl <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_cnt[i] <= '0;
                    r_lvl[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_clr = (w_wr && (address == LP_ADDR_EDGE)) ? writedata[3:0] : 4'h0;

    // A press detected on the same edge as a clear of that bit keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= 4'h0;
            r_mask    <= 4'h0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_press;
            if (w_wr && (address == LP_ADDR_MASK)) begin
                r_mask <= writedata[3:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            LP_ADDR_LVL:  w_rd_mux[3:0] = ~r_lvl;
            LP_ADDR_MASK: w_rd_mux[3:0] = r_mask;
            LP_ADDR_SYNC: w_rd_mux[3:0] = r_sync2;
            LP_ADDR_EDGE: w_rd_mux[3:0] = r_edgecap;
            default:      w_rd_mux      = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_de1_soc_key_ctrl.sv
// Bench for de1_soc_key_ctrl with a short debounce window: directed scenarios plus random key
// activity and bus traffic, compared each cycle against a window-based behavioural model.
module tb_de1_soc_key_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: sync pipeline, last D pre-edge synchronized samples, accepted levels, registers.
    logic [3:0]  m_s1, m_s2, m_lvl, m_ec, m_mask;
    logic [31:0] m_rd;
    logic [3:0]  hist[$];

    de1_soc_key_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_irq();
        return |(m_ec & m_mask);
    endfunction

    function automatic void model_reset();
        m_s1   = 4'hF;
        m_s2   = 4'hF;
        m_lvl  = 4'hF;
        m_ec   = 4'h0;
        m_mask = 4'h0;
        m_rd   = '0;
        hist.delete();
    endfunction

    // A key's level flips when each of its last D synchronized samples disagreed with it.
    function automatic void model_edge();
        logic       wr;
        logic [3:0] acc;
        logic [3:0] clr;
        wr = chipselect && !write_n;
        case (address)
            2'd0:    m_rd = {28'h0, ~m_lvl};
            2'd1:    m_rd = {28'h0, m_mask};
            2'd2:    m_rd = {28'h0, m_s2};
            default: m_rd = {28'h0, m_ec};
        endcase
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        for (int i = 0; i < 4; i++) begin
            acc[i] = (hist.size() == D);
            for (int k = 0; k < hist.size(); k++)
                if (hist[k][i] == m_lvl[i]) acc[i] = 1'b0;
        end
        clr    = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_ec   = (m_ec & ~clr) | (acc & m_lvl);
        m_lvl  = m_lvl ^ acc;
        if (wr && address == 2'd1) m_mask = writedata[3:0];
        m_s2   = m_s1;
        m_s1   = in_port;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'h0, irq}, {31'h0, m_irq()});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [3:0] d, input logic [1:0] rd_after);
        address    = a;
        writedata  = {28'h0, d};
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = rd_after;
    endtask

    task automatic read_reg(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick();
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        model_reset();
        #1;
        check("reset_rd", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        read_reg(2'd2, "reset_sync", 32'hF);
        read_reg(2'd0, "reset_lvl", 32'h0);

        // Clean press of key0: accepted on edge 6, visible on the read loaded at edge 7.
        address = 2'd0;
        in_port = 4'hE;
        ticks(6);
        check("press_rd_edge6", readdata, 32'h0);
        tick();
        check("press_rd_edge7", readdata, 32'h1);
        read_reg(2'd3, "press_edgecap", 32'h1);
        check("press_irq_masked", {31'h0, irq}, 32'h0);
        in_port = 4'hF;
        ticks(8);
        check("release_keeps_ec", readdata, 32'h1);
        bus_wr(2'd3, 4'h1, 2'd3);
        tick();
        check("clear_ec", readdata, 32'h0);

        // Bounce on key1: never holds long enough to be accepted.
        address = 2'd0;
        for (int i = 0; i < 10; i++) begin
            in_port[1] = ~in_port[1];
            ticks(2);
        end
        in_port[1] = 1'b1;
        ticks(8);
        check("bounce_lvl", readdata, 32'h0);
        read_reg(2'd3, "bounce_ec", 32'h0);
        check("bounce_irq", {31'h0, irq}, 32'h0);

        // Interrupt path on key0.
        bus_wr(2'd1, 4'h1, 2'd1);
        tick();
        check("mask_rd", readdata, 32'h1);
        in_port = 4'hE;
        ticks(5);
        check("irq_before_accept", {31'h0, irq}, 32'h0);
        tick();
        check("irq_after_accept", {31'h0, irq}, 32'h1);
        bus_wr(2'd3, 4'h1, 2'd3);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        in_port = 4'hF;
        ticks(10);
        check("irq_release", {31'h0, irq}, 32'h0);

        // Clear of key2 lands on the very edge its press is accepted.
        in_port = 4'hB;
        ticks(5);
        bus_wr(2'd3, 4'h4, 2'd3);
        tick();
        check("collision_ec", readdata, 32'h4);
        in_port = 4'hF;
        ticks(8);
        bus_wr(2'd3, 4'h4, 2'd3);

        // Keys 0 and 3 pressed one cycle apart.
        bus_wr(2'd1, 4'h9, 2'd3);
        in_port = 4'hE;
        tick();
        in_port = 4'h6;
        ticks(8);
        check("multi_ec", readdata, 32'h9);
        bus_wr(2'd3, 4'h1, 2'd3);
        check("multi_irq_after_clr1", {31'h0, irq}, 32'h1);
        bus_wr(2'd3, 4'h8, 2'd3);
        check("multi_irq_after_clr8", {31'h0, irq}, 32'h0);
        in_port = 4'hF;
        ticks(8);

        // Reset in the middle of key1's debounce, with key0 already latched and irq high.
        in_port = 4'hE;
        ticks(7);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        in_port = 4'hC;
        ticks(4);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_rd", readdata, 32'h0);
        check("midreset_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        check("midreset_rd_clk", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd0;
        ticks(6);
        check("post_reset_edge6", readdata, 32'h0);
        tick();
        check("post_reset_edge7", readdata, 32'h3);
        read_reg(2'd3, "post_reset_ec", 32'h3);

        // Random key activity and bus traffic against the model.
        for (int n = 0; n < 60; n++) begin
            in_port = 4'($urandom);
            for (int c = 0; c < int'($urandom_range(1, 2 * D + 2)); c++) begin
                address    = 2'($urandom);
                chipselect = ($urandom_range(0, 3) == 0);
                write_n    = ($urandom_range(0, 1) == 0);
                writedata  = $urandom;
                tick();
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
